uni_bus_arbiter: RTL and testbench
==================================

# uni_bus_arbiter

Arbiter and transaction sequencer for the unidirectional bus with 2 masters and 4 slaves. It decides which master owns the bus and drives the 2-bit `ack` code that steers the master-to-slave multiplexers: 00 = idle, 01 = master 1, 10 = master 2. It also latches the target slave from the winning master's address and drives the slave-side select and enables. Master 1 has fixed priority; a consecutive-grant limit keeps master 2 from starving, and a watchdog frees the bus if a slave never completes.

## Interface
- `ADDR_WIDTH`, 32: master address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the slave.
- `TIMEOUT`, 15: maximum ownership cycles without `done` before the bus is forcibly released (≥1).
- `MAX_CONSEC`, 4: maximum back-to-back master 1 grants while `req2` is pending (≥1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req1` in 1: master 1 bus request (high priority).
- `req2` in 1: master 2 bus request (low priority).
- `addr1` in ADDR_WIDTH: master 1 address.
- `addr2` in ADDR_WIDTH: master 2 address.
- `done` in 1: addressed slave completed the transfer (1-cycle pulse).
- `ack` out 2: grant code and master-mux select. 00 none, 01 M1, 10 M2; 11 is never driven.
- `slv_sel` out 2: latched target slave index; select for the slave-to-master response mux.
- `slv_en` out 4: one-hot slave enable, equal to 1<<slv_sel while `ack`≠00, else 0.
- `busy` out 1: high while `ack`≠00.
- `timeout` out 1: 1-cycle pulse when the watchdog fires.

## Operation
- FSM has three states: IDLE, OWN1, OWN2. All outputs are registered.
- **IDLE**
  - If `req1` and not (`req2` and consec==MAX_CONSEC): go to OWN1 and set consec to consec+1 if `req2`, else 0.
  - Else if `req2`: go to OWN2 and set consec to 0.
  - Else stay in IDLE.
- **Slave latch:** on entry to OWN1/OWN2, `slv_sel` latches the top 2 address bits of the winner. `slv_sel` holds through the whole ownership and keeps its value in IDLE.
- **OWN1 / OWN2 exit**
  - Exit to IDLE when `done`=1, or when the owner's req=0 (abort), or when the watchdog fires.
  - Otherwise stay; address changes during ownership are ignored.
- **Watchdog:** wdog counter width is $clog2(TIMEOUT+1).
  - It clears to 0 on entry to OWN1/OWN2 and increments each cycle in an OWN state.
  - When wdog==TIMEOUT-1 and `done`=0, it fires: `timeout` pulses for 1 cycle and the FSM returns to IDLE.
- **Turnaround:** every exit from an OWN state passes through at least one IDLE cycle with `ack`=00. There are no direct OWN1↔OWN2 transitions.
- **Fairness counter:** consec saturates at MAX_CONSEC. It clears whenever `req2` is sampled low in IDLE or M2 is granted.
- **Reset:** `rst_n`=0 at a clock edge forces IDLE in every state, including mid-transfer, with no `timeout` pulse. Reset values:
  - `ack`=00, `slv_sel`=00, `slv_en`=0000, `busy`=0, `timeout`=0.
  - consec=0, wdog=0.

## Timing
- **Grant latency:** `req` sampled at edge N in IDLE gives `ack`, `slv_sel`, `slv_en` and `busy` valid after edge N (1 cycle).
- **Release latency:** `done` or a req drop sampled at edge N gives `ack`=00 after edge N. The earliest next grant is after edge N+1.
- **Minimum ownership:** 1 cycle (`done` at the first owned edge).
- **Maximum ownership:** exactly TIMEOUT cycles.
- **Simultaneous `done` and watchdog expiry:** `done` wins and `timeout` stays 0.
- **Simultaneous `req1` and `req2` in IDLE:** M1 wins unless consec==MAX_CONSEC.
- **Owner's req drops in the same cycle as `done`:** a normal release with no abort distinction.

## Test plan
- **Reset, then single master:** `rst_n` low for 2 cycles, then `req2`=1 and `addr2`=0xC000_0000. Expect `ack`=10, `slv_sel`=3, `slv_en`=1000 one cycle later. `done` 3 cycles later gives `ack`=00 on the next cycle.
- **Simultaneous requests:** `req1`=`req2`=1 held continuously, `done` pulsed at every grant. Expect the grant sequence M1,M1,M1,M1,M2,M1,… with MAX_CONSEC=4, and `ack`=00 between every grant.
- **Watchdog:** M1 granted to slave 1, no `done`, TIMEOUT=15. Expect `timeout` pulse in the 15th owned cycle, then `ack`=00 and `slv_en`=0000.
- **Done on the last watchdog cycle:** `done` asserted in the 15th owned cycle. Expect `timeout`=0 and a normal release.
- **Abort and address stability:**
  - M2 owns slave 2, `req2` dropped with no `done`: expect `ack`=00 next cycle.
  - During an ownership, change `addr1`: `slv_sel` must not change.
- **Reset mid-transfer:** while in OWN1, pulse `rst_n` low for 1 cycle. Expect all outputs at reset values after that edge, and a fresh grant possible 1 cycle after `rst_n` returns high.

Source files
------------

// File: rtl/uni_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the slave-side muxes.
//   req1/req2   : master bus requests (master 1 has priority)
//   addr1/addr2 : master addresses, top two bits pick the slave
//   done        : one-cycle completion pulse from the addressed slave
//   ack         : grant code / master-mux select (00 none, 01 M1, 10 M2)
//   slv_sel     : latched target slave, response-mux select
//   slv_en      : one-hot slave enable while the bus is owned
//   busy        : bus owned
//   timeout     : one-cycle pulse when the watchdog forcibly releases the bus
// The master modport is the requester/slave side.
// The slave modport is the arbiter side.
interface uni_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req1;
  logic                  req2;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [ADDR_WIDTH-1:0] addr2;
  logic                  done;
  logic [1:0]            ack;
  logic [1:0]            slv_sel;
  logic [3:0]            slv_en;
  logic                  busy;
  logic                  timeout;

  modport master (
    output req1, req2, addr1, addr2, done,
    input  ack, slv_sel, slv_en, busy, timeout
  );

  modport slave (
    input  req1, req2, addr1, addr2, done,
    output ack, slv_sel, slv_en, busy, timeout
  );
endinterface

// File: rtl/uni_bus_arbiter.sv
// Two-master / four-slave bus arbiter and transaction sequencer.
//
// Master 1 has fixed priority. A fairness counter lets master 2 in after
// MAX_CONSEC back-to-back master 1 grants while req2 waits. A watchdog
// releases the bus after TIMEOUT owned cycles without done. Every release
// goes through at least one idle cycle. All outputs are registered.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uni_bus_arbiter_if.slave (requests in; grant/select/enables out)
module uni_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int MAX_CONSEC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uni_bus_arbiter_if.slave   bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int CC_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CC_W-1:0] CC_MAX  = CC_W'(MAX_CONSEC);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

  state_t          state;
  logic [WD_W-1:0] wdog;
  logic [CC_W-1:0] consec;

  logic [1:0] sel1, sel2;
  logic       owner_req;
  logic       wd_fire;
  logic       m1_wins;

  assign sel1 = bus.addr1[ADDR_WIDTH-1 -: 2];
  assign sel2 = bus.addr2[ADDR_WIDTH-1 -: 2];

  // Only the slave-select bits of the addresses are consumed here.
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.addr1[ADDR_WIDTH-3:0], bus.addr2[ADDR_WIDTH-3:0]};

  assign owner_req = (state == OWN1) ? bus.req1 : bus.req2;
  // done on the last allowed cycle takes precedence over the watchdog.
  assign wd_fire   = (wdog == WD_LAST) && !bus.done;
  // M1 loses a simultaneous request only once it has used up its streak.
  assign m1_wins   = bus.req1 && !(bus.req2 && consec == CC_MAX);

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wdog        <= '0;
      consec      <= '0;
      bus.ack     <= 2'b00;
      bus.slv_sel <= 2'b00;
      bus.slv_en  <= 4'b0000;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (m1_wins) begin
            state       <= OWN1;
            bus.ack     <= 2'b01;
            bus.busy    <= 1'b1;
            bus.slv_sel <= sel1;
            bus.slv_en  <= onehot(sel1);
            wdog        <= '0;
            // consec < CC_MAX here whenever req2 is high, so +1 cannot overflow.
            consec      <= bus.req2 ? consec + 1'b1 : '0;
          end else if (bus.req2) begin
            state       <= OWN2;
            bus.ack     <= 2'b10;
            bus.busy    <= 1'b1;
            bus.slv_sel <= sel2;
            bus.slv_en  <= onehot(sel2);
            wdog        <= '0;
            consec      <= '0;
          end else begin
            consec      <= '0;
          end
        end
        OWN1, OWN2: begin
          if (bus.done || !owner_req || wd_fire) begin
            // slv_sel deliberately keeps its value through idle.
            state       <= IDLE;
            bus.ack     <= 2'b00;
            bus.busy    <= 1'b0;
            bus.slv_en  <= 4'b0000;
            bus.timeout <= wd_fire;
          end else begin
            wdog        <= wdog + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.ack     <= 2'b00;
          bus.busy    <= 1'b0;
          bus.slv_en  <= 4'b0000;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uni_bus_arbiter.sv
// Directed bench for uni_bus_arbiter (ADDR_WIDTH=32, TIMEOUT=15, MAX_CONSEC=4).
// Inputs change 1ns after a rising edge; outputs are checked at the same
// point, so each check sees the result of the edge just taken.
module tb_uni_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  uni_bus_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  uni_bus_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(15), .MAX_CONSEC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] sel, input logic tmo);
    check({tag, " ack"},     32'(bus.ack),     32'h0);
    check({tag, " slv_en"},  32'(bus.slv_en),  32'h0);
    check({tag, " busy"},    32'(bus.busy),    32'h0);
    check({tag, " timeout"}, 32'(bus.timeout), 32'(tmo));
    check({tag, " slv_sel"}, 32'(bus.slv_sel), 32'(sel));
  endtask

  task automatic check_own(input string tag, input logic [1:0] ack, input logic [1:0] sel);
    check({tag, " ack"},     32'(bus.ack),     32'(ack));
    check({tag, " slv_sel"}, 32'(bus.slv_sel), 32'(sel));
    check({tag, " slv_en"},  32'(bus.slv_en),  32'(4'b0001 << sel));
    check({tag, " busy"},    32'(bus.busy),    32'h1);
    check({tag, " timeout"}, 32'(bus.timeout), 32'h0);
  endtask

  logic [1:0] seq [6];

  initial begin
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    rst_n     = 1'b0;
    bus.req1  = 1'b0;
    bus.req2  = 1'b0;
    bus.addr1 = 32'h0;
    bus.addr2 = 32'h0;
    bus.done  = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    check_idle("reset", 2'd0, 1'b0);

    // Single master 2 to slave 3, done three cycles after the grant.
    rst_n     = 1'b1;
    bus.req2  = 1'b1;
    bus.addr2 = 32'hC000_0000;
    tick();
    check_own("m2 grant", 2'b10, 2'd3);
    tick();
    tick();
    check_own("m2 hold", 2'b10, 2'd3);
    bus.done = 1'b1;
    tick();
    check_idle("m2 done", 2'd3, 1'b0);
    bus.done = 1'b0;
    bus.req2 = 1'b0;
    tick();
    check_idle("post m2 idle", 2'd3, 1'b0);

    // Both masters requesting continuously: M1 x4, M2, M1.
    bus.req1  = 1'b1;
    bus.req2  = 1'b1;
    bus.addr1 = 32'h4000_0000;
    bus.addr2 = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_own($sformatf("fair grant %0d", i), seq[i], (seq[i] == 2'b01) ? 2'd1 : 2'd2);
      bus.done = 1'b1;
      tick();
      check($sformatf("fair gap %0d ack", i), 32'(bus.ack), 32'h0);
      bus.done = 1'b0;
    end
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    tick();

    // Watchdog: M1 to slave 1, no done; address change ignored mid-ownership.
    bus.req1  = 1'b1;
    bus.addr1 = 32'h4000_0000;
    tick();
    check_own("wd grant", 2'b01, 2'd1);
    bus.addr1 = 32'hC000_0000;
    for (int k = 1; k <= 14; k++) tick();
    check_own("wd cycle15", 2'b01, 2'd1);
    tick();
    check_idle("wd fire", 2'd1, 1'b1);
    bus.req1 = 1'b0;
    tick();
    check_idle("wd after", 2'd1, 1'b0);

    // done on the last watchdog cycle wins over the timeout.
    bus.req1  = 1'b1;
    bus.addr1 = 32'h0000_0000;
    tick();
    check_own("lastdone grant", 2'b01, 2'd0);
    for (int k = 1; k <= 14; k++) tick();
    bus.done = 1'b1;
    tick();
    check_idle("lastdone release", 2'd0, 1'b0);
    bus.done = 1'b0;
    bus.req1 = 1'b0;
    tick();

    // Abort: M2 owns slave 2 and drops req2 without done.
    bus.req2  = 1'b1;
    bus.addr2 = 32'h8000_0000;
    tick();
    check_own("abort grant", 2'b10, 2'd2);
    bus.req2 = 1'b0;
    tick();
    check_idle("abort release", 2'd2, 1'b0);
    tick();

    // Reset in the middle of an M1 ownership.
    bus.req1  = 1'b1;
    bus.addr1 = 32'h4000_0000;
    tick();
    check_own("midrst grant", 2'b01, 2'd1);
    rst_n = 1'b0;
    tick();
    check_idle("midrst reset", 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_own("midrst regrant", 2'b01, 2'd1);
    bus.req1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
